// File: rtl/conv_param_server.sv
// Conv weight and batch-norm gamma/beta parameter store, filled from a host word stream,
// with zero-latency reads. Define PARAM_CHECKSUM_EN to require a trailing checksum word.
module conv_param_server #(
    parameter int N            = 16,
    parameter int K            = 3,
    parameter int IN_CHANNELS  = 1,
    parameter int OUT_CHANNELS = 16,
    localparam int W_DEPTH     = K * K * IN_CHANNELS * OUT_CHANNELS,
    localparam int BN_DEPTH    = 2 * OUT_CHANNELS,
    localparam int WA          = $clog2(W_DEPTH),
    localparam int BA          = $clog2(BN_DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load_start,
    input  logic [N-1:0]  load_data,
    input  logic          load_valid,
    output logic          load_ready,
    input  logic          weight_en,
    input  logic [WA-1:0] weight_addr,
    output logic [N-1:0]  weight_data,
    input  logic          bn_en,
    input  logic [BA-1:0] bn_addr,
    output logic [N-1:0]  bn_data,
    output logic          params_ready,
    output logic          param_error
);
    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] LOAD_W  = 3'd1;
    localparam logic [2:0] LOAD_BN = 3'd2;
    localparam logic [2:0] CHECK   = 3'd3;
    localparam logic [2:0] READY   = 3'd4;

    logic [2:0]    state_q, state_d;
    logic [WA-1:0] cnt_q, cnt_d;
    logic          load_ready_q;
    logic          params_ready_q;
    logic          xfer;
    logic          wr_w, wr_bn;

    logic [N-1:0] wmem  [W_DEPTH];
    logic [N-1:0] bnmem [BN_DEPTH];

`ifdef PARAM_CHECKSUM_EN
    logic [15:0] sum_q, sum_d;
    logic        err_q, err_d;
`endif

    assign xfer = load_valid && load_ready_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
`ifdef PARAM_CHECKSUM_EN
        sum_d   = sum_q;
        err_d   = err_q;
`endif
        // A restart wins over any same-cycle transfer, which is dropped.
        if (load_start) begin
            state_d = LOAD_W;
            cnt_d   = '0;
`ifdef PARAM_CHECKSUM_EN
            sum_d   = '0;
            err_d   = 1'b0;
`endif
        end else if (xfer) begin
            case (state_q)
                LOAD_W: begin
                    cnt_d = cnt_q + 1'b1;
`ifdef PARAM_CHECKSUM_EN
                    sum_d = sum_q + 16'(load_data);
`endif
                    if (cnt_q == WA'(W_DEPTH - 1)) begin
                        state_d = LOAD_BN;
                        cnt_d   = '0;
                    end
                end
                LOAD_BN: begin
                    cnt_d = cnt_q + 1'b1;
`ifdef PARAM_CHECKSUM_EN
                    sum_d = sum_q + 16'(load_data);
`endif
                    if (cnt_q == WA'(BN_DEPTH - 1)) begin
                        cnt_d = '0;
`ifdef PARAM_CHECKSUM_EN
                        state_d = CHECK;
`else
                        state_d = READY;
`endif
                    end
                end
`ifdef PARAM_CHECKSUM_EN
                CHECK: begin
                    if (16'(load_data) == sum_q) begin
                        state_d = READY;
                    end else begin
                        state_d = IDLE;
                        err_d   = 1'b1;
                    end
                end
`endif
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q        <= IDLE;
            cnt_q          <= '0;
            load_ready_q   <= 1'b0;
            params_ready_q <= 1'b0;
`ifdef PARAM_CHECKSUM_EN
            sum_q          <= '0;
            err_q          <= 1'b0;
`endif
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            load_ready_q   <= (state_d == LOAD_W) || (state_d == LOAD_BN) || (state_d == CHECK);
            params_ready_q <= (state_d == READY);
`ifdef PARAM_CHECKSUM_EN
            sum_q          <= sum_d;
            err_q          <= err_d;
`endif
        end
    end

    // Stores are never reset; contents are only trusted while params_ready is high.
    assign wr_w  = xfer && !load_start && (state_q == LOAD_W);
    assign wr_bn = xfer && !load_start && (state_q == LOAD_BN);

    always_ff @(posedge clk) begin
        if (wr_w)  wmem[cnt_q]            <= load_data;
        if (wr_bn) bnmem[cnt_q[BA-1:0]]   <= load_data;
    end

    assign weight_data = (params_ready_q && weight_en && (int'(weight_addr) < W_DEPTH))
                         ? wmem[weight_addr] : '0;
    assign bn_data     = (params_ready_q && bn_en && (int'(bn_addr) < BN_DEPTH))
                         ? bnmem[bn_addr] : '0;

    assign load_ready   = load_ready_q;
    assign params_ready = params_ready_q;
`ifdef PARAM_CHECKSUM_EN
    assign param_error  = err_q;
`else
    assign param_error  = 1'b0;
`endif
endmodule

// File: tb/tb_conv_param_server.sv
// Directed bench for conv_param_server: load, gapped load, restart, reset mid-load,
// out-of-range reads, and the checksum path when PARAM_CHECKSUM_EN is defined.
module tb_conv_param_server;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        load_start = 1'b0;
    logic [15:0] load_data = '0;
    logic        load_valid = 1'b0;
    logic        load_ready;
    logic        weight_en = 1'b0;
    logic [7:0]  weight_addr = '0;
    logic [15:0] weight_data;
    logic        bn_en = 1'b0;
    logic [4:0]  bn_addr = '0;
    logic [15:0] bn_data;
    logic        params_ready;
    logic        param_error;

    int n_checks = 0;
    int n_pass   = 0;

    conv_param_server dut (
        .clk          (clk),
        .rst          (rst),
        .load_start   (load_start),
        .load_data    (load_data),
        .load_valid   (load_valid),
        .load_ready   (load_ready),
        .weight_en    (weight_en),
        .weight_addr  (weight_addr),
        .weight_data  (weight_data),
        .bn_en        (bn_en),
        .bn_addr      (bn_addr),
        .bn_data      (bn_data),
        .params_ready (params_ready),
        .param_error  (param_error)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        load_start = 1'b1;
        step();
        load_start = 1'b0;
    endtask

    task automatic rd_w(input logic [7:0] a, input logic [15:0] exp, input string tag);
        weight_en = 1'b1; weight_addr = a; #1;
        check(tag, 32'(weight_data), 32'(exp));
        weight_en = 1'b0;
    endtask

    task automatic rd_bn(input logic [4:0] a, input logic [15:0] exp, input string tag);
        bn_en = 1'b1; bn_addr = a; #1;
        check(tag, 32'(bn_data), 32'(exp));
        bn_en = 1'b0;
    endtask

    // Streams 144 weights (i, or a fixed value) then 32 BN words 0x0100+i.
    task automatic load_stream(input bit do_start, input bit fixed_w, input logic [15:0] wval,
                               input bit gapped, input logic [15:0] sum_delta);
        logic [15:0] s;
        logic [15:0] word;
        s = '0;
        if (do_start) pulse_start();
        for (int i = 0; i < 176; i++) begin
            if (i < 144) word = fixed_w ? wval : 16'(i);
            else         word = 16'h0100 + 16'(i - 144);
            if (gapped) begin
                load_valid = 1'b0;
                step();
                check("load_ready_gap", 32'(load_ready), 32'd1);
            end
            load_valid = 1'b1;
            load_data  = word;
            s = s + word;
            if (i == 175) check("not_ready_before_last", 32'(params_ready), 32'd0);
            step();
        end
        load_valid = 1'b0;
`ifdef PARAM_CHECKSUM_EN
        check("check_state_ready", 32'(load_ready), 32'd1);
        load_valid = 1'b1;
        load_data  = s + sum_delta;
        step();
        load_valid = 1'b0;
        check("params_ready_after_sum", 32'(params_ready), (sum_delta == 16'd0) ? 32'd1 : 32'd0);
        check("param_error_after_sum", 32'(param_error), (sum_delta == 16'd0) ? 32'd0 : 32'd1);
`else
        check("params_ready_after_load", 32'(params_ready), 32'd1);
        check("param_error_tied", 32'(param_error), 32'd0);
`endif
    endtask

    initial begin
        // Reset and idle reads
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        rd_w(8'd5, 16'h0000, "idle_weight_read");
        check("reset_params_ready", 32'(params_ready), 32'd0);
        check("reset_load_ready", 32'(load_ready), 32'd0);
        check("reset_param_error", 32'(param_error), 32'd0);

        // Full contiguous load
        load_stream(1'b1, 1'b0, 16'h0, 1'b0, 16'h0);
        check("ready_load_ready_low", 32'(load_ready), 32'd0);
        rd_w(8'd143, 16'h008F, "w143");
        rd_w(8'd77, 16'h004D, "w77");
        rd_bn(5'd16, 16'h0110, "bn16");
        weight_en = 1'b1; weight_addr = 8'd0; bn_en = 1'b1; bn_addr = 5'd0; #1;
        check("dual_bn0", 32'(bn_data), 32'h0100);
        check("dual_w0", 32'(weight_data), 32'h0000);
        weight_en = 1'b0; bn_en = 1'b0;

        // Gapped load gives the same contents
        load_stream(1'b1, 1'b0, 16'h0, 1'b1, 16'h0);
        rd_w(8'd100, 16'h0064, "gap_w100");
        rd_bn(5'd31, 16'h011F, "gap_bn31");

        // Restart after 50 words; restart word with load_valid is discarded
        pulse_start();
        check("reload_drops_ready", 32'(params_ready), 32'd0);
        rd_w(8'd0, 16'h0000, "read_during_reload");
        for (int i = 0; i < 50; i++) begin
            load_valid = 1'b1; load_data = 16'h1234; step();
        end
        load_start = 1'b1; load_data = 16'h5555; step();
        load_start = 1'b0;
        load_stream(1'b0, 1'b1, 16'hAAAA, 1'b0, 16'h0);
        for (int a = 0; a < 144; a++) rd_w(8'(a), 16'hAAAA, "reload_w");
        rd_bn(5'd0, 16'h0100, "reload_bn0");
        rd_bn(5'd31, 16'h011F, "reload_bn31");

        // Out-of-range and disabled reads
        rd_w(8'd200, 16'h0000, "w_out_of_range");
        weight_en = 1'b0; weight_addr = 8'd3; #1;
        check("w_disabled", 32'(weight_data), 32'h0000);
        bn_en = 1'b0; bn_addr = 5'd3; #1;
        check("bn_disabled", 32'(bn_data), 32'h0000);

        // Reset at word 100 abandons the load
        pulse_start();
        for (int i = 0; i < 100; i++) begin
            load_valid = 1'b1; load_data = 16'(i); step();
        end
        load_valid = 1'b0;
        rst = 1'b0; step(); rst = 1'b1;
        check("midrst_load_ready", 32'(load_ready), 32'd0);
        check("midrst_params_ready", 32'(params_ready), 32'd0);
        rd_w(8'd3, 16'h0000, "midrst_read");
        for (int i = 0; i < 3; i++) begin
            load_valid = 1'b1; load_data = 16'hFFFF; step();
            check("idle_ignores_valid", 32'(load_ready), 32'd0);
        end
        load_valid = 1'b0;
        check("idle_stays_not_ready", 32'(params_ready), 32'd0);

`ifdef PARAM_CHECKSUM_EN
        // Bad checksum then recovery
        load_stream(1'b1, 1'b0, 16'h0, 1'b0, 16'h0001);
        check("bad_sum_load_ready", 32'(load_ready), 32'd0);
        pulse_start();
        check("start_clears_error", 32'(param_error), 32'd0);
        load_stream(1'b0, 1'b0, 16'h0, 1'b0, 16'h0);
        rd_w(8'd143, 16'h008F, "sum_ok_w143");
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish, observed hang expected completion");
        $fatal(1, "timeout");
    end
endmodule
